// File: rtl/bcd_display_scan_pkg.sv
// Shared constants for the 7-segment display blocks: active-low segment codes
// ordered {g,f,e,d,c,b,a}, plus the slot phase type used by the scanner.
package bcd_display_scan_pkg;

    localparam logic [6:0] SEG_0    = 7'h40;
    localparam logic [6:0] SEG_1    = 7'h79;
    localparam logic [6:0] SEG_2    = 7'h24;
    localparam logic [6:0] SEG_3    = 7'h30;
    localparam logic [6:0] SEG_4    = 7'h19;
    localparam logic [6:0] SEG_5    = 7'h12;
    localparam logic [6:0] SEG_6    = 7'h02;
    localparam logic [6:0] SEG_7    = 7'h78;
    localparam logic [6:0] SEG_8    = 7'h00;
    localparam logic [6:0] SEG_9    = 7'h10;
    localparam logic [6:0] SEG_DASH = 7'h3F;
    localparam logic [6:0] SEG_OFF  = 7'h7F;

    typedef enum logic {
        PHASE_DEAD,
        PHASE_LIT
    } phase_e;

endpackage

// File: rtl/bcd_display_scan_bcd_to_seg7.sv
// Combinational BCD to active-low 7-segment decoder. Non-decimal codes A-F
// show a dash so corrupted counter values are visible rather than silent.
module bcd_to_seg7
    import bcd_display_scan_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_DASH;
        case (bcd_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/bcd_display_scan.sv
// Time-multiplexed 7-segment scanner: per-frame snapshot of the BCD digits,
// dead-time at the start of each slot, leading-zero blanking, registered outputs.
module bcd_display_scan
    import bcd_display_scan_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 500,
    parameter int LZ_BLANK     = 1
)
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CW-1:0] SLOT_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

    logic [CW-1:0]           slotCnt_q, slotCnt_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] shadow_q;
    logic [NUM_DIGITS-1:0]   shadowDp_q;
    logic [NUM_DIGITS-1:0]   an_q, anD;
    logic [6:0]              seg_q, segD;
    logic                    dp_q, dpD;
    logic                    frameDone_q;

    logic                    slotWrap, frameWrap;
    logic [NUM_DIGITS-1:0]   blank;
    logic                    zeroRun;
    logic [3:0]              curDigit;
    logic [6:0]              curSeg;
    phase_e                  phase;

    always_comb begin
        slotWrap  = (slotCnt_q == SLOT_LAST);
        frameWrap = slotWrap && (idx_q == IDX_LAST);
        slotCnt_d = slotWrap ? '0 : slotCnt_q + 1'b1;
        idx_d     = idx_q;
        if (slotWrap) begin
            idx_d = frameWrap ? '0 : idx_q + 1'b1;
        end
    end

    // A digit is blank only while every digit above it is also zero with no dp.
    always_comb begin
        blank   = '0;
        zeroRun = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            zeroRun  = zeroRun & (shadow_q[4*i +: 4] == 4'd0) & ~shadowDp_q[i];
            blank[i] = zeroRun & (LZ_BLANK != 0);
        end
    end

    assign curDigit = shadow_q[4*idx_q +: 4];

    bcd_to_seg7 uDecode (
        .bcd_i (curDigit),
        .seg_o (curSeg)
    );

    always_comb begin
        phase = PHASE_LIT;
        if ((slotCnt_q < BLANK_END) || blank[idx_q]) begin
            phase = PHASE_DEAD;
        end
        anD  = '1;
        segD = SEG_OFF;
        dpD  = 1'b1;
        if (phase == PHASE_LIT) begin
            anD[idx_q] = 1'b0;
            segD       = curSeg;
            dpD        = ~shadowDp_q[idx_q];
        end
    end

    // The snapshot lands on the same edge the last slot ends, so a new frame
    // always begins in dead-time with consistent data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            slotCnt_q   <= '0;
            idx_q       <= '0;
            shadow_q    <= '0;
            shadowDp_q  <= '0;
            an_q        <= '1;
            seg_q       <= SEG_OFF;
            dp_q        <= 1'b1;
            frameDone_q <= 1'b0;
        end else begin
            slotCnt_q   <= slotCnt_d;
            idx_q       <= idx_d;
            if (frameWrap) begin
                shadow_q   <= digits_in;
                shadowDp_q <= dp_in;
            end
            frameDone_q <= frameWrap;
            an_q        <= anD;
            seg_q       <= segD;
            dp_q        <= dpD;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign frame_done = frameDone_q;

endmodule
